// File: rtl/apb_arb.sv
// -----------------------------------------------------------------------------
// apb_arb
//
// Two-master APB3 arbiter. It sits between the AHB-to-APB bridge (master 0)
// and the APB slave decoder, and lets a second APB master (DMA or debug port,
// master 1) share the single downstream APB bus.
//
// Each winning request is latched and replayed downstream as a clean
// SETUP/ACCESS pair. Arbitration is round-robin on simultaneous requests. A
// watchdog terminates any transfer whose slave keeps PREADY low for TIMEOUT
// consecutive ACCESS cycles and returns an error to the owning master.
//
// Parameters
//   TIMEOUT  PREADY-low ACCESS cycles before forced termination (0 = off)
//   TO_W     width of the watchdog counter, 2**TO_W must exceed TIMEOUT
//
// Ports
//   HCLK, HRESETn               clock, synchronous active-low reset
//   PSELMx, PENABLEMx           master x request / enable (enable is unused)
//   PADDRMx, PWRITEMx, PWDATAMx master x transfer attributes
//   PRDATAMx, PREADYMx,
//   PSLVERRMx                   response to master x (combinational)
//   PSEL, PENABLE               downstream select / enable (registered)
//   PADDR, PWRITE, PWDATA       downstream latched attributes (registered)
//   PRDATA, PREADY, PSLVERR     downstream response
//   GNT                         one-hot owner of the current transfer
// -----------------------------------------------------------------------------
module apb_arb #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        HCLK,
    input  logic        HRESETn,

    input  logic        PSELM0,
    input  logic        PENABLEM0,
    input  logic [31:0] PADDRM0,
    input  logic        PWRITEM0,
    input  logic [31:0] PWDATAM0,
    output logic [31:0] PRDATAM0,
    output logic        PREADYM0,
    output logic        PSLVERRM0,

    input  logic        PSELM1,
    input  logic        PENABLEM1,
    input  logic [31:0] PADDRM1,
    input  logic        PWRITEM1,
    input  logic [31:0] PWDATAM1,
    output logic [31:0] PRDATAM1,
    output logic        PREADYM1,
    output logic        PSLVERRM1,

    output logic        PSEL,
    output logic        PENABLE,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,

    output logic [1:0]  GNT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Watchdog compare value; guarded so TIMEOUT=0 never underflows.
    localparam bit              WD_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = WD_EN ? TO_W'(TIMEOUT - 1) : '0;

    state_t          state;
    state_t          state_nx;
    logic [1:0]      gnt_nx;
    logic            last;       // 0: M0 owned the previous grant, 1: M1
    logic            last_nx;
    logic [TO_W-1:0] cnt;
    logic [TO_W-1:0] cnt_nx;
    logic            capture;    // latch winner's attributes this cycle
    logic            win1;       // winner is master 1
    logic            done;       // transfer ends in this ACCESS cycle
    logic            wd_fire;    // ... because the watchdog expired
    logic [31:0]     rsp_data;
    logic            rsp_err;

    // Master enables carry no information for the replayed transfer.
    logic unused_penable;
    assign unused_penable = ^{PENABLEM0, PENABLEM1};

    // -------------------------------------------------------------------------
    // State and downstream registers
    // -------------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state   <= IDLE;
            GNT     <= 2'b00;
            last    <= 1'b1;
            cnt     <= '0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
        end else begin
            state   <= state_nx;
            GNT     <= gnt_nx;
            last    <= last_nx;
            cnt     <= cnt_nx;
            PSEL    <= (state_nx != IDLE);
            PENABLE <= (state_nx == ACCESS);
            // Attributes only move on a grant, so they stay stable through
            // the whole transfer and hold their last value while idle.
            if (capture) begin
                PADDR  <= win1 ? PADDRM1  : PADDRM0;
                PWRITE <= win1 ? PWRITEM1 : PWRITEM0;
                PWDATA <= win1 ? PWDATAM1 : PWDATAM0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state, arbitration and watchdog
    // -------------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        gnt_nx   = GNT;
        last_nx  = last;
        cnt_nx   = cnt;
        capture  = 1'b0;
        win1     = 1'b0;
        done     = 1'b0;
        wd_fire  = 1'b0;

        case (state)
            IDLE: begin
                if (PSELM0 || PSELM1) begin
                    // On contention the master that did not win last time
                    // takes the bus, so a re-requesting master cannot starve
                    // the other one.
                    win1     = PSELM1 && (!PSELM0 || !last);
                    capture  = 1'b1;
                    gnt_nx   = win1 ? 2'b10 : 2'b01;
                    last_nx  = win1;
                    state_nx = SETUP;
                end
            end

            SETUP: begin
                cnt_nx   = '0;
                state_nx = ACCESS;
            end

            ACCESS: begin
                wd_fire = !PREADY && WD_EN && (cnt == TO_LAST);
                if (PREADY || wd_fire) begin
                    done     = 1'b1;
                    gnt_nx   = 2'b00;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            default: begin
                gnt_nx   = 2'b00;
                state_nx = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Response steering: only the owner sees the completing cycle; a watchdog
    // abort returns zero data with an error.
    // -------------------------------------------------------------------------
    always_comb begin
        rsp_data  = PREADY ? PRDATA  : 32'h0;
        rsp_err   = PREADY ? PSLVERR : 1'b1;

        PREADYM0  = 1'b0;
        PSLVERRM0 = 1'b0;
        PRDATAM0  = 32'h0;
        PREADYM1  = 1'b0;
        PSLVERRM1 = 1'b0;
        PRDATAM1  = 32'h0;

        if (done && GNT[0]) begin
            PREADYM0  = 1'b1;
            PSLVERRM0 = rsp_err;
            PRDATAM0  = rsp_data;
        end
        if (done && GNT[1]) begin
            PREADYM1  = 1'b1;
            PSLVERRM1 = rsp_err;
            PRDATAM1  = rsp_data;
        end
    end

endmodule

// File: doc/apb_arb.md
# apb_arb

Two-master APB3 arbiter inserted between the AHB-to-APB bridge and the APB slave decoder in the APB subsystem. It lets a second APB master (DMA or debug port) share the single APB bus with the bridge. Masters are granted round-robin, and each granted transfer is re-issued downstream as a clean setup/access pair. A watchdog terminates any transfer that a slave never completes.

## Interface
- `TIMEOUT`, default 255: the number of consecutive PREADY-low access cycles before forced termination. 0 disables the watchdog.
- `TO_W`, default 8: width of the watchdog counter. Must satisfy 2^TO_W > TIMEOUT.

- `HCLK` in 1: clock.
- `HRESETn` in 1: synchronous, active-low reset.
- `PSELM0`, `PSELM1` in 1: master select/request.
- `PENABLEM0`, `PENABLEM1` in 1: master enable. Accepted but not used for sequencing.
- `PADDRM0`, `PADDRM1` in 32: master address.
- `PWRITEM0`, `PWRITEM1` in 1: master direction.
- `PWDATAM0`, `PWDATAM1` in 32: master write data.
- `PRDATAM0`, `PRDATAM1` out 32: read data returned to the master.
- `PREADYM0`, `PREADYM1` out 1: transfer completion to the master.
- `PSLVERRM0`, `PSLVERRM1` out 1: error to the master.
- `PSEL`, `PENABLE` out 1: downstream select/enable, towards the decoder.
- `PADDR` out 32, `PWRITE` out 1, `PWDATA` out 32: downstream transfer attributes, registered.
- `PRDATA` in 32, `PREADY` in 1, `PSLVERR` in 1: downstream response.
- `GNT` out 2: one-hot owner of the current transfer. 00 when idle.

## Operation
- The state machine has three states: IDLE, SETUP and ACCESS. It resets to IDLE.
- **IDLE:**
  - If neither PSELM is high, stay in IDLE.
  - If exactly one PSELMx is high, grant master x.
  - If both are high, grant the master that is not `last`.
  - On a grant: capture the winner's PADDRMx, PWRITEMx and PWDATAMx into the downstream registers, set GNT, set `last` to the winner, and go to SETUP.
- **SETUP:** PSEL=1, PENABLE=0. Go to ACCESS unconditionally.
- **ACCESS:** PSEL=1, PENABLE=1.
  - If PREADY=1, the granted master sees PREADYMx=1, PRDATAMx=PRDATA and PSLVERRMx=PSLVERR, all combinational, in the same cycle. The next state is IDLE.
  - If PREADY=0 and TIMEOUT≠0 and `cnt`==TIMEOUT-1: PREADYMx=1, PSLVERRMx=1, PRDATAMx=0. The next state is IDLE.
  - Otherwise `cnt` is incremented. `cnt` is cleared on entry to ACCESS.
- **Non-granted or idle master:** PREADYMx=0, PSLVERRMx=0, PRDATAMx=0 in all cycles. A requesting master therefore stalls in its access phase until its grant completes.
- **Round-robin pointer `last`:** resets to 1, so M0 wins the first simultaneous request. It updates only on a grant.
- **Back-to-back requests:** a master holding PSELMx high after completion re-requests in the next IDLE cycle. If the other master is waiting, the other master wins, so there is no starvation.
- **Mid-transfer deassertion:** a master that drops PSELMx mid-transfer violates APB. The latched transfer still completes downstream and the response is discarded.
- **Address/data stability:** the downstream PADDR, PWRITE and PWDATA hold their latched values from SETUP through the last ACCESS cycle. Outside a transfer they keep their last value.
- **Reset:**
  - HRESETn=0 sampled at any edge, including mid-ACCESS, forces IDLE, GNT=00, last=1 and cnt=0.
  - PSEL and PENABLE are 0 from the next cycle. All master PREADY/PSLVERR/PRDATA outputs are 0.
  - PADDR and PWDATA reset to 0, PWRITE to 0.

## Timing
- Master setup phase at cycle 0 (arbiter IDLE, no contention):
  - cycle 1: downstream SETUP.
  - cycle 2: downstream ACCESS.
  - With a zero-wait slave, PREADYMx=1 at cycle 2.
- Each transfer costs the master exactly one extra cycle compared with direct connection.
- The minimum downstream transfer is 2 cycles, followed by at least 1 IDLE cycle. Bus throughput is therefore at most one transfer per 3 cycles.
- The loser of a simultaneous request starts its downstream SETUP 3 cycles after the winner's, assuming a zero-wait slave.
- The watchdog fires on the TIMEOUT-th consecutive PREADY-low ACCESS cycle. PSEL drops on the following cycle.
- PSEL, PENABLE, PADDR, PWRITE, PWDATA and GNT are registered. PRDATAMx, PREADYMx and PSLVERRMx are combinational from state and downstream response.

## Test plan
- **Single M0 write, zero-wait slave:** PSELM0=1, PADDRM0=0x1000_0004, PWDATAM0=0x55 at cycle 0. Expect PSEL=1/PENABLE=0 at cycle 1, PENABLE=1 at cycle 2, PREADYM0=1 at cycle 2, and PWDATA=0x55 throughout.
- **Simultaneous requests after reset:** M0 reads 0x10, M1 reads 0x20. Expect M0 granted first (GNT=01) and M1 next (GNT=10). With slave PRDATA=0xA5 then 0x5A, expect PRDATAM0=0xA5, PRDATAM1=0x5A, and PREADYM1=0 while M0 is active.
- **Fairness:** both masters request continuously for 6 transfers. Expect the GNT sequence 01,10,01,10,01,10.
- **Wait states and error:** slave holds PREADY=0 for 3 ACCESS cycles, then PREADY=1 with PSLVERR=1. Expect PREADYM0=1 and PSLVERRM0=1 only on the 4th ACCESS cycle, with PADDR stable throughout.
- **Watchdog:** with TIMEOUT=4, the slave never asserts PREADY. Expect PREADYM1=1, PSLVERRM1=1 and PRDATAM1=0 on the 4th ACCESS cycle, then PSEL=0 on the next cycle.
- **Reset mid-ACCESS:** HRESETn=0 for 1 cycle. Expect PSEL=0, GNT=00 and PREADYMx=0 in the next cycle. After release, simultaneous requests grant M0 first.
